// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encoding for the common data bus arbiter.
package cdb_arbiter_pkg;

  // Reorder-id, register-value and opcode widths used by the ROB/RS/LSB.
  localparam int RBID_W = 4;
  localparam int RLEN_W = 32;
  localparam int OPC_W  = 6;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // Round-robin pick: a lone non-empty source wins; on a tie rr selects
  // (0 = ALU preferred, 1 = LSB preferred).
  function automatic cdb_src_e rr_pick(input logic alu_ne, input logic lsb_ne,
                                       input logic rr);
    return (lsb_ne && (!alu_ne || rr)) ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO: push/pop/flush with occupancy flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/count: flush empties the FIFO, otherwise push and pop update independently.
  always_comb begin
    wr_en    = en && !flush && push && !full;
    rd_en    = en && !flush && pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and occupancy, cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter putting ALU and LSB writebacks onto one registered CDB.
// Each source is buffered in its own FIFO; a flush discards everything pending.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int RB_W   = RBID_W,
  parameter int DATA_W = RLEN_W,
  parameter int OP_W   = OPC_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RB_W-1:0]   alu_reorder,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [OP_W-1:0]   alu_op,
  input  logic              lsb_valid,
  output logic              lsb_ready,
  input  logic [RB_W-1:0]   lsb_reorder,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic [OP_W-1:0]   lsb_op,
  output logic              cdb_valid,
  output logic [RB_W-1:0]   cdb_reorder,
  output logic [DATA_W-1:0] cdb_val,
  output logic [OP_W-1:0]   cdb_op,
  output logic              cdb_src
);
  localparam int ENT_W = RB_W + DATA_W + OP_W;

  logic [ENT_W-1:0]  alu_head, lsb_head, win_head;
  logic              alu_empty, alu_full, lsb_empty, lsb_full;
  logic              alu_push, lsb_push, alu_pop, lsb_pop;
  cdb_src_e          winner;
  logic              rr_q, rr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [RB_W-1:0]   cdb_reorder_q, cdb_reorder_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  logic [OP_W-1:0]   cdb_op_q, cdb_op_d;
  logic              cdb_src_q, cdb_src_d;

  // Ready looks only at pre-edge occupancy, so a full FIFO never passes through.
  assign alu_ready = !alu_full && rdy && !flush && rst;
  assign lsb_ready = !lsb_full && rdy && !flush && rst;
  assign alu_push  = alu_valid && alu_ready;
  assign lsb_push  = lsb_valid && lsb_ready;

  cdb_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   ({alu_reorder, alu_val, alu_op}),
    .dout  (alu_head),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   ({lsb_reorder, lsb_val, lsb_op}),
    .dout  (lsb_head),
    .empty (lsb_empty),
    .full  (lsb_full)
  );

  // Grant selection: pop one head per enabled cycle and flip preference away from the winner.
  always_comb begin
    winner        = rr_pick(!alu_empty, !lsb_empty, rr_q);
    win_head      = (winner == SRC_LSB) ? lsb_head : alu_head;
    alu_pop       = 1'b0;
    lsb_pop       = 1'b0;
    rr_d          = rr_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_reorder_d = cdb_reorder_q;
    cdb_val_d     = cdb_val_q;
    cdb_op_d      = cdb_op_q;
    cdb_src_d     = cdb_src_q;
    if (rdy) begin
      if (flush || (alu_empty && lsb_empty)) begin
        cdb_valid_d = 1'b0;
      end else begin
        alu_pop     = (winner == SRC_ALU);
        lsb_pop     = (winner == SRC_LSB);
        rr_d        = (winner == SRC_ALU);
        cdb_valid_d = 1'b1;
        cdb_src_d   = winner;
        {cdb_reorder_d, cdb_val_d, cdb_op_d} = win_head;
      end
    end
  end

  // CDB output registers and round-robin pointer, cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q          <= 1'b0;
      cdb_valid_q   <= 1'b0;
      cdb_reorder_q <= '0;
      cdb_val_q     <= '0;
      cdb_op_q      <= '0;
      cdb_src_q     <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_reorder_q <= cdb_reorder_d;
      cdb_val_q     <= cdb_val_d;
      cdb_op_q      <= cdb_op_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_reorder = cdb_reorder_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_op      = cdb_op_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the per-source FIFOs and round-robin grant.
module tb_cdb_arbiter;
  localparam int RB_W = 4, DATA_W = 32, OP_W = 6, DEPTH = 2;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h13;

  typedef struct packed {
    logic [RB_W-1:0]   r;
    logic [DATA_W-1:0] v;
    logic [OP_W-1:0]   op;
  } ent_t;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic alu_valid, lsb_valid;
  logic alu_ready, lsb_ready;
  logic [RB_W-1:0] alu_reorder, lsb_reorder, cdb_reorder;
  logic [DATA_W-1:0] alu_val, lsb_val, cdb_val;
  logic [OP_W-1:0] alu_op, lsb_op, cdb_op;
  logic cdb_valid, cdb_src;

  cdb_arbiter #(.RB_W(RB_W), .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reorder(alu_reorder),
    .alu_val(alu_val), .alu_op(alu_op),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_reorder(lsb_reorder),
    .lsb_val(lsb_val), .lsb_op(lsb_op),
    .cdb_valid(cdb_valid), .cdb_reorder(cdb_reorder), .cdb_val(cdb_val),
    .cdb_op(cdb_op), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  ent_t qa[$];
  ent_t ql[$];
  bit   m_pref_lsb;
  bit   e_valid, e_src;
  logic [RB_W-1:0] e_r;
  logic [DATA_W-1:0] e_v;
  logic [OP_W-1:0] e_op;
  bit   last_acc_a, last_acc_l;
  logic [RB_W-1:0] next_a_id, next_l_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    ql.delete();
    m_pref_lsb = 1'b0;
    e_valid = 1'b0; e_src = 1'b0; e_r = '0; e_v = '0; e_op = '0;
  endtask

  // One clock: check ready before the edge, advance the model, check the CDB after it.
  task automatic cycle();
    bit ra, rl, acc_a, acc_l;
    ent_t e;
    #1;
    ra = (qa.size() < DEPTH) && rdy && !flush && rst;
    rl = (ql.size() < DEPTH) && rdy && !flush && rst;
    check("alu_ready", 64'(alu_ready), 64'(ra));
    check("lsb_ready", 64'(lsb_ready), 64'(rl));
    acc_a = alu_valid && ra;
    acc_l = lsb_valid && rl;
    @(posedge clk);
    if (rst && rdy) begin
      if (flush) begin
        qa.delete();
        ql.delete();
        e_valid = 1'b0;
      end else begin
        if (qa.size() > 0 && (ql.size() == 0 || !m_pref_lsb)) begin
          e = qa.pop_front(); e_src = 1'b0; e_valid = 1'b1; m_pref_lsb = 1'b1;
          e_r = e.r; e_v = e.v; e_op = e.op;
        end else if (ql.size() > 0) begin
          e = ql.pop_front(); e_src = 1'b1; e_valid = 1'b1; m_pref_lsb = 1'b0;
          e_r = e.r; e_v = e.v; e_op = e.op;
        end else begin
          e_valid = 1'b0;
        end
        if (acc_a) qa.push_back('{alu_reorder, alu_val, alu_op});
        if (acc_l) ql.push_back('{lsb_reorder, lsb_val, lsb_op});
      end
    end
    last_acc_a = acc_a;
    last_acc_l = acc_l;
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    if (e_valid || !rst) begin
      check("cdb_reorder", 64'(cdb_reorder), 64'(e_r));
      check("cdb_val", 64'(cdb_val), 64'(e_v));
      check("cdb_op", 64'(cdb_op), 64'(e_op));
      check("cdb_src", 64'(cdb_src), 64'(e_src));
    end
  endtask

  // Producers hold an offered-but-unaccepted payload; otherwise offer a new one if wanted.
  task automatic drive_producers(input bit want_a, input bit want_l);
    if (!(alu_valid && !last_acc_a)) begin
      alu_valid = want_a;
      if (want_a) begin
        alu_reorder = next_a_id; next_a_id = next_a_id + 1'b1;
        alu_val = $urandom; alu_op = OP_W'($urandom);
      end
    end
    if (!(lsb_valid && !last_acc_l)) begin
      lsb_valid = want_l;
      if (want_l) begin
        lsb_reorder = next_l_id; next_l_id = next_l_id + 1'b1;
        lsb_val = $urandom; lsb_op = OP_W'($urandom);
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic pulse_reset();
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(cdb_valid), 64'd0);
    check("async_rst_alu_ready", 64'(alu_ready), 64'd0);
    check("async_rst_lsb_ready", 64'(lsb_ready), 64'd0);
    model_clear();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    alu_reorder = '0; alu_val = '0; alu_op = '0;
    lsb_reorder = '0; lsb_val = '0; lsb_op = '0;
    last_acc_a = 1'b0; last_acc_l = 1'b0;
    next_a_id = '0; next_l_id = 4'd8;
    model_clear();

    // Reset state
    #1;
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_lsb_ready", 64'(lsb_ready), 64'd0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_reorder", 64'(cdb_reorder), 64'd0);
    check("rst_cdb_val", 64'(cdb_val), 64'd0);
    check("rst_cdb_src", 64'(cdb_src), 64'd0);
    cycle();
    cycle();
    rst = 1'b1;

    // Single ALU push: visible on the CDB after the second edge
    alu_valid = 1'b1; alu_reorder = 4'd3; alu_val = 32'h1234; alu_op = OP_ADDI;
    cycle();
    alu_valid = 1'b0;
    cycle();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_reorder", 64'(cdb_reorder), 64'd3);
    check("single_val", 64'(cdb_val), 64'h1234);
    check("single_op", 64'(cdb_op), 64'(OP_ADDI));
    check("single_src", 64'(cdb_src), 64'd0);
    cycle();
    check("single_pulse_end", 64'(cdb_valid), 64'd0);

    // Same-edge pushes after reset: ALU first, then LSB
    pulse_reset();
    alu_valid = 1'b1; alu_reorder = 4'd1; alu_val = 32'hA1; alu_op = 6'd2;
    lsb_valid = 1'b1; lsb_reorder = 4'd2; lsb_val = 32'hB2; lsb_op = 6'd3;
    cycle();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    cycle();
    check("tie_first_reorder", 64'(cdb_reorder), 64'd1);
    check("tie_first_src", 64'(cdb_src), 64'd0);
    cycle();
    check("tie_second_reorder", 64'(cdb_reorder), 64'd2);
    check("tie_second_src", 64'(cdb_src), 64'd1);
    cycle();
    check("tie_idle", 64'(cdb_valid), 64'd0);

    // Both sources streaming: FIFOs fill, grants alternate, held payloads accepted later
    for (int i = 0; i < 12; i++) begin
      drive_producers(1'b1, 1'b1);
      cycle();
    end
    drive_producers(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      drive_producers(1'b0, 1'b0);
    end

    // Flush with ALU and LSB entries pending
    drive_producers(1'b1, 1'b1);
    cycle();
    drive_producers(1'b1, 1'b0);
    cycle();
    drive_producers(1'b1, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_valid", 64'(cdb_valid), 64'd0);
    alu_valid = 1'b0; lsb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_flush_idle", 64'(cdb_valid), 64'd0);
    end
    alu_valid = 1'b1; alu_reorder = 4'd9; alu_val = 32'hCAFE; alu_op = 6'd5;
    cycle();
    alu_valid = 1'b0;
    cycle();
    check("post_flush_new", 64'(cdb_reorder), 64'd9);
    check("post_flush_new_valid", 64'(cdb_valid), 64'd1);
    last_acc_a = 1'b1; last_acc_l = 1'b1;

    // rdy low with entries pending, then resume
    for (int i = 0; i < 3; i++) begin
      drive_producers(1'b1, 1'b1);
      cycle();
    end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_producers(1'b1, 1'b1);
      if (i == 1) flush = 1'b1;
      cycle();
      flush = 1'b0;
    end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_producers(1'b1, 1'b0);
      cycle();
    end

    // Async reset mid-stream with entries pending
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive_producers(1'b0, 1'b0);
      cycle();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_producers($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 29) == 0);
      cycle();
      if (i == 200) pulse_reset();
    end
    rdy = 1'b1; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_producers(1'b0, 1'b0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the two ROB writeback producers, ALU and LSB, onto one registered common data bus (CDB).
- The CDB is broadcast to the ROB, RS and LSB.
- Each producer gets a small per-source FIFO, so a collision stalls nothing upstream until that FIFO fills.
- Round-robin selection between sources; a flush on branch mispredict discards all pending results.

Parameters:
- RB_W, 4, reorder-id width (matches `RBID)
- DATA_W, 32, result value width
- OP_W, 6, opcode width
- DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  discard all pending and in-flight results
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_reorder  in  RB_W  ROB slot of ALU result
- alu_val  in  DATA_W  ALU result
- alu_op  in  OP_W  ALU opcode
- lsb_valid  in  1  LSB result offered
- lsb_ready  out  1  LSB FIFO can accept
- lsb_reorder  in  RB_W  ROB slot of LSB result
- lsb_val  in  DATA_W  load data
- lsb_op  in  OP_W  LSB opcode
- cdb_valid  out  1  broadcast valid this cycle
- cdb_reorder  out  RB_W  broadcast ROB slot
- cdb_val  out  DATA_W  broadcast value
- cdb_op  out  OP_W  broadcast opcode
- cdb_src  out  1  0 = ALU, 1 = LSB

Behaviour:
- Reset (rst low, async):
  - FIFO counts and pointers = 0; rr = 0 (ALU preferred first).
  - cdb_valid = 0; cdb_reorder, cdb_val, cdb_op, cdb_src = 0.
  - alu_ready = lsb_ready = 0 while rst is low.
- xxx_ready is combinational: (count < DEPTH) && rdy && !flush && rst.
  - Depends on the count before the edge; a full FIFO stays not-ready even if it pops that cycle (no pass-through).
- Push: a source FIFO writes {reorder, val, op} on an edge where xxx_valid && xxx_ready.
  - valid without ready means the producer must hold its payload stable.
- Arbitration, each edge with rdy=1 and flush=0:
  - Both FIFOs non-empty: pop the head of ALU if rr=0, else LSB; then rr <= ~winner.
  - One FIFO non-empty: pop it; rr <= ~winner.
  - Neither non-empty: cdb_valid <= 0; rr unchanged.
  - The popped head is registered onto cdb_*, with cdb_valid <= 1 and cdb_src = winner.
- Latency: an entry pushed at edge k is eligible at edge k+1, so it is visible on the CDB for the cycle after edge k+1 (minimum 1 cycle). No combinational bypass.
- cdb_valid is a single-cycle pulse per result. Back-to-back results produce consecutive pulses.
- Fairness: with both sources continuously non-empty, grants strictly alternate. No source waits more than 1 grant.
- Simultaneous push and pop on the same FIFO is legal; the count is unchanged.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Flush (sync, rdy=1):
  - At the edge, both FIFOs are emptied and cdb_valid <= 0.
  - Same-edge pushes are dropped (ready is already 0).
  - rr is unchanged.
- rdy low: no push, no pop, rr and cdb_* hold their values, ready = 0. Flush is ignored while rdy is low.
- Reset mid-operation: all pending entries are lost. The first CDB output after release requires a fresh push.
- Opcode filtering is not done here: stores and JALR targets are broadcast as-is and consumers decode cdb_op.

Decomposition:
- defines.v holds `RBID/`RLEN widths and opcode constants; the parameter defaults derive from them.
- One sub-module, cdb_fifo: parameterised DEPTH/width, push/pop/flush, count, empty/full. Instantiated twice (ALU, LSB).
- Arbitration and CDB registers live in cdb_arbiter.

Test Plan:
- Single ALU push: {reorder=3, val=0x1234, op=ADDI} at edge 1 -> cdb_valid=1 for one cycle after edge 2, cdb_reorder=3, cdb_val=0x1234, cdb_src=0.
- Same-edge ALU {r=1} and LSB {r=2} pushes after reset -> cycle 1 CDB r=1 src=0, cycle 2 CDB r=2 src=1, then cdb_valid=0.
- Both sources streaming every cycle for 10 cycles -> cdb_src alternates 0,1,0,1,...; alu_ready drops to 0 once the ALU FIFO holds 2, and no entry is lost or reordered within a source.
- Full LSB FIFO (2 entries) with lsb_valid held -> lsb_ready=0 until the pop edge, ready again the next cycle; the held entry is accepted once ready returns to 1.
- Flush with 2 ALU + 1 LSB entries pending -> cdb_valid=0 the next cycle, and no stale reorder ids appear afterwards; a new push after flush is broadcast normally.
- rdy low for 3 cycles with entries pending -> cdb_* frozen and ready=0; broadcasting resumes in the same order when rdy returns. Async rst low mid-stream -> cdb_valid=0 immediately, without waiting for a clock edge.
